// File: rtl/bsg_wormhole_broadcast.sv
// Single-input, two-output wormhole router node. The header's destination
// field steers the whole packet to the local port (0), the pass-through
// port (1), or both. The data path is combinational; a per-output "sent"
// mask ensures that a broadcast flit is consumed only after both outputs
// have taken it, and that no output sees the same flit twice.
module bsg_wormhole_broadcast #(
   parameter int width_p            = 32,
   parameter int payload_len_bits_p = 4,
   parameter int coord_bits_p       = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    v_i,
   input  logic [width_p-1:0]      data_i,
   output logic                    ready_and_o,
   output logic [1:0]              v_o,
   output logic [1:0][width_p-1:0] data_o,
   input  logic [1:0]              ready_and_i
);

   typedef enum logic {
      ST_BODY = 1'b0,
      ST_HDR  = 1'b1
   } state_e;

   state_e                        state_q, state_d;
   logic [1:0]                    route_q, route_d;
   logic [1:0]                    sent_q, sent_d;
   logic [payload_len_bits_p-1:0] count_q, count_d;

   logic [coord_bits_p-1:0]       dest;
   logic [payload_len_bits_p-1:0] len;
   logic [1:0]                    hdr_route;
   logic [1:0]                    route;
   logic                          xfer;

   assign dest = data_i[coord_bits_p-1:0];
   assign len  = data_i[coord_bits_p +: payload_len_bits_p];

   // Decode the header destination and select the route in force this cycle.
   always_comb begin
      hdr_route = 2'b10;
      if (dest == '0)
         hdr_route = 2'b01;
      else if (dest == '1)
         hdr_route = 2'b11;
      route = (state_q == ST_HDR) ? hdr_route : route_q;
   end

   // Handshake outputs; everything is held quiet while reset is asserted.
   always_comb begin
      v_o         = {2{v_i & reset_i}} & route & ~sent_q;
      ready_and_o = reset_i & (&(~route | sent_q | ready_and_i));
      data_o[0]   = data_i;
      data_o[1]   = data_i;
      xfer        = v_i & ready_and_o;
   end

   // Packet framing and per-output acceptance tracking.
   always_comb begin
      state_d = state_q;
      route_d = route_q;
      count_d = count_q;
      sent_d  = sent_q;
      if (xfer) begin
         sent_d = '0;
         if (state_q == ST_HDR) begin
            if (len != '0) begin
               route_d = hdr_route;
               count_d = len;
               state_d = ST_BODY;
            end
         end else begin
            count_d = count_q - 1'b1;
            if (count_q == payload_len_bits_p'(1))
               state_d = ST_HDR;
         end
      end else if (v_i) begin
         sent_d = sent_q | (v_o & ready_and_i);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= ST_HDR;
         route_q <= '0;
         count_q <= '0;
         sent_q  <= '0;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
         count_q <= count_d;
         sent_q  <= sent_d;
      end
   end

endmodule

// File: tb/tb_bsg_wormhole_broadcast.sv
module tb_bsg_wormhole_broadcast;

   logic             clk_i = 1'b0;
   logic             reset_i;
   logic             v_i;
   logic [31:0]      data_i;
   logic             ready_and_o;
   logic [1:0]       v_o;
   logic [1:0][31:0] data_o;
   logic [1:0]       ready_and_i;

   int nchk  = 0;
   int nfail = 0;

   bsg_wormhole_broadcast #(
      .width_p(32),
      .payload_len_bits_p(4),
      .coord_bits_p(4)
   ) dut (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .v_i(v_i),
      .data_i(data_i),
      .ready_and_o(ready_and_o),
      .v_o(v_o),
      .data_o(data_o),
      .ready_and_i(ready_and_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b0; v_i = 1'b1; data_i = 32'h0000002F; ready_and_i = 2'b11;
      #2;
      nchk++;
      if (v_o !== 2'b00) begin nfail++; $display("FAIL reset_v_o got %b want 00", v_o); end
      nchk++;
      if (ready_and_o !== 1'b0) begin nfail++; $display("FAIL reset_ready got %b want 0", ready_and_o); end
      step(); step();
      v_i = 1'b0; ready_and_i = 2'b00;
      step();
      reset_i = 1'b1;
      step();
      #2;
      nchk++;
      if (v_o !== 2'b00) begin nfail++; $display("FAIL idle_v_o got %b want 00", v_o); end
   endtask

   task automatic test_local();
      logic [31:0] f [3];
      f = '{32'h00000020, 32'hBEEF0000, 32'hBEEF0001};
      ready_and_i = 2'b01;
      for (int i = 0; i < 3; i++) begin
         v_i = 1'b1; data_i = f[i];
         #2;
         nchk++;
         if (v_o !== 2'b01) begin nfail++; $display("FAIL local_v_o[%0d] got %b want 01", i, v_o); end
         nchk++;
         if (ready_and_o !== 1'b1) begin nfail++; $display("FAIL local_ready[%0d] got %b want 1", i, ready_and_o); end
         nchk++;
         if (data_o[0] !== f[i]) begin nfail++; $display("FAIL local_data[%0d] got %h want %h", i, data_o[0], f[i]); end
         step();
      end
      v_i = 1'b0; ready_and_i = 2'b00;
      step();
   endtask

   task automatic test_broadcast();
      logic [31:0] f [3];
      f = '{32'h0000002F, 32'hBEEF0002, 32'hBEEF0003};
      for (int i = 0; i < 3; i++) begin
         v_i = 1'b1; data_i = f[i];
         ready_and_i = 2'b01;
         #2;
         nchk++;
         if (v_o !== 2'b11) begin nfail++; $display("FAIL bcast_v_o_a[%0d] got %b want 11", i, v_o); end
         nchk++;
         if (ready_and_o !== 1'b0) begin nfail++; $display("FAIL bcast_ready_a[%0d] got %b want 0", i, ready_and_o); end
         nchk++;
         if (data_o[1] !== f[i] || data_o[0] !== f[i]) begin
            nfail++; $display("FAIL bcast_data[%0d] got %h/%h want %h", i, data_o[1], data_o[0], f[i]);
         end
         step();
         ready_and_i = 2'b11;
         #2;
         nchk++;
         if (v_o !== 2'b10) begin nfail++; $display("FAIL bcast_v_o_b[%0d] got %b want 10", i, v_o); end
         nchk++;
         if (ready_and_o !== 1'b1) begin nfail++; $display("FAIL bcast_ready_b[%0d] got %b want 1", i, ready_and_o); end
         step();
      end
      v_i = 1'b0; ready_and_i = 2'b00;
      step();
   endtask

   task automatic test_passthrough();
      logic [31:0] f [3];
      f = '{32'h00000023, 32'hBEEF0004, 32'hBEEF0005};
      for (int i = 0; i < 3; i++) begin
         v_i = 1'b1; data_i = f[i];
         ready_and_i = 2'b01;
         #2;
         nchk++;
         if (v_o !== 2'b10) begin nfail++; $display("FAIL pass_v_o_a[%0d] got %b want 10", i, v_o); end
         nchk++;
         if (ready_and_o !== 1'b0) begin nfail++; $display("FAIL pass_ready_a[%0d] got %b want 0", i, ready_and_o); end
         step();
         ready_and_i = 2'b10;
         #2;
         nchk++;
         if (v_o !== 2'b10) begin nfail++; $display("FAIL pass_v_o_b[%0d] got %b want 10", i, v_o); end
         nchk++;
         if (ready_and_o !== 1'b1) begin nfail++; $display("FAIL pass_ready_b[%0d] got %b want 1", i, ready_and_o); end
         nchk++;
         if (data_o[1] !== f[i]) begin nfail++; $display("FAIL pass_data[%0d] got %h want %h", i, data_o[1], f[i]); end
         step();
      end
      v_i = 1'b0; ready_and_i = 2'b00;
      step();
   endtask

   task automatic test_zero_len();
      logic [31:0] f [4];
      logic [1:0]  ev [4];
      f  = '{32'h00000003, 32'h0000000F, 32'h00000000, 32'h00000023};
      ev = '{2'b10, 2'b11, 2'b01, 2'b10};
      ready_and_i = 2'b11;
      for (int i = 0; i < 4; i++) begin
         v_i = 1'b1; data_i = f[i];
         #2;
         nchk++;
         if (v_o !== ev[i]) begin nfail++; $display("FAIL zlen_v_o[%0d] got %b want %b", i, v_o, ev[i]); end
         nchk++;
         if (ready_and_o !== 1'b1) begin nfail++; $display("FAIL zlen_ready[%0d] got %b want 1", i, ready_and_o); end
         if (i < 3) step();
      end
      // last header (len 2) is left presented but not consumed
      v_i = 1'b0; ready_and_i = 2'b00;
      step();
   endtask

   task automatic test_stall();
      v_i = 1'b1; data_i = 32'h0000001F; ready_and_i = 2'b01;
      #2;
      nchk++;
      if (v_o !== 2'b11) begin nfail++; $display("FAIL stall_v_o_a got %b want 11", v_o); end
      step();
      v_i = 1'b0;
      #2;
      nchk++;
      if (v_o !== 2'b00) begin nfail++; $display("FAIL stall_v_o_idle got %b want 00", v_o); end
      step();
      v_i = 1'b1; ready_and_i = 2'b00;
      #2;
      nchk++;
      if (v_o !== 2'b10) begin nfail++; $display("FAIL stall_v_o_held got %b want 10", v_o); end
      nchk++;
      if (ready_and_o !== 1'b0) begin nfail++; $display("FAIL stall_ready_held got %b want 0", ready_and_o); end
      step();
      ready_and_i = 2'b10;
      #2;
      nchk++;
      if (ready_and_o !== 1'b1) begin nfail++; $display("FAIL stall_ready_done got %b want 1", ready_and_o); end
      step();
      data_i = 32'hBEEF0009; ready_and_i = 2'b11;
      #2;
      nchk++;
      if (v_o !== 2'b11) begin nfail++; $display("FAIL stall_body_v_o got %b want 11", v_o); end
      step();
      data_i = 32'h00000000; ready_and_i = 2'b00;
      #2;
      nchk++;
      if (v_o !== 2'b01) begin nfail++; $display("FAIL stall_next_hdr got %b want 01", v_o); end
      v_i = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_packet();
      v_i = 1'b1; data_i = 32'h0000002F; ready_and_i = 2'b11;
      step();
      data_i = 32'hBEEF0003; ready_and_i = 2'b01;
      #2;
      nchk++;
      if (v_o !== 2'b11) begin nfail++; $display("FAIL rstmid_body_v_o got %b want 11", v_o); end
      step();
      #2;
      reset_i = 1'b0;
      #1;
      nchk++;
      if (v_o !== 2'b00 || ready_and_o !== 1'b0) begin
         nfail++; $display("FAIL rstmid_async got v_o=%b rdy=%b want 00/0", v_o, ready_and_o);
      end
      step();
      reset_i = 1'b1;
      data_i = 32'h00000000; ready_and_i = 2'b00;
      #2;
      nchk++;
      if (v_o !== 2'b01) begin nfail++; $display("FAIL rstmid_hdr_v_o got %b want 01", v_o); end
      ready_and_i = 2'b01;
      #1;
      nchk++;
      if (ready_and_o !== 1'b1) begin nfail++; $display("FAIL rstmid_hdr_ready got %b want 1", ready_and_o); end
      step();
      v_i = 1'b0; ready_and_i = 2'b00;
      step();
   endtask

   initial begin
      reset_i = 1'b0; v_i = 1'b0; data_i = '0; ready_and_i = 2'b00;
      step();
      test_reset();
      test_local();
      test_broadcast();
      test_passthrough();
      test_zero_len();
      test_stall();
      test_reset_mid_packet();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/bsg_wormhole_broadcast.md
Name: bsg_wormhole_broadcast

Overview:
- Single-input, two-output wormhole router node for a linear or broadcast chain.
- Each packet is a header flit followed by N payload flits.
- The header's destination coordinate steers the whole packet to one of three places:
  - the local port (output 0),
  - the pass-through port (output 1),
  - both ports (broadcast).
- It sits between an upstream wormhole link and a local client plus a downstream node. It is zero-latency: combinational data path, valid/ready-and handshake on every port.

Parameters:
- width_p, 32: flit width in bits.
- payload_len_bits_p, 4: width of the header length field, which gives the number of payload flits after the header.
- coord_bits_p, 4: width of the header destination field. Required: coord_bits_p + payload_len_bits_p <= width_p.

Ports:
- clk_i, in, 1: clock; all state updates on the rising edge.
- reset_i, in, 1: reset; asynchronous, active-low (asserted when 0).
- v_i, in, 1: input flit valid.
- data_i, in, width_p: input flit.
- ready_and_o, out, 1: input ready. A flit transfers when v_i & ready_and_o.
- v_o, out, 2: per-output valid. Bit 0 is local, bit 1 is pass-through.
- data_o, out, 2 x width_p: per-output flit. Both entries always equal data_i, unmodified (the header is not rewritten).
- ready_and_i, in, 2: per-output ready. Output i transfers when v_o[i] & ready_and_i[i].

Behaviour:
- Header fields:
  - dest = data_i[coord_bits_p-1:0].
  - len = data_i[coord_bits_p +: payload_len_bits_p].
  - Upper bits are ignored and passed through.
- Route mask (2 bits) decoded from dest:
  - dest == 0: route = 01 (local only).
  - dest == all-ones: route = 11 (broadcast).
  - any other value: route = 10 (pass-through).
- State:
  - hdr_r: 1 means the next input flit is a header.
  - route_r: 2 bits.
  - count_r: payload_len_bits_p bits, flits remaining.
  - sent_r: 2 bits, outputs that already accepted the current flit.
- Active route:
  - In the header state, the active route is decoded combinationally from data_i.
  - Otherwise it is route_r.
- Outputs:
  - v_o[i] = v_i & route[i] & ~sent_r[i].
  - ready_and_o = AND over i of (~route[i] | sent_r[i] | ready_and_i[i]).
- Broadcast completion rule: an input flit is consumed only once every routed output has accepted it, in the same or earlier cycles. An output that already accepted the flit is never shown the same flit again (no duplicates).
- On a cycle with v_i and no input transfer: sent_r |= v_o & ready_and_i.
- On an input transfer, sent_r is cleared, and then:
  - Header with len == 0: remain in the header state (one-flit packet).
  - Header with len > 0: route_r <= decoded route, count_r <= len, hdr_r <= 0.
  - Body flit: count_r decrements; when it reaches 0 after the last payload flit, hdr_r <= 1.
- If v_i deasserts mid-flit, sent_r is held. The upstream must not change a presented flit before it is consumed.
- Reset (reset_i == 0, asynchronous):
  - State: hdr_r = 1, count_r = 0, route_r = 0, sent_r = 0.
  - Outputs: ready_and_o = 0, v_o = 00.
- Releasing reset mid-packet restarts in the header state. Any partial packet is the upstream's responsibility.
- With v_i = 0, v_o = 00.
- ready_and_o may depend combinationally on ready_and_i and data_i. There is no combinational path from ready_and_i to v_o.

Test Plan:
- Local packet:
  - Stimulus: header 0x00000020 (len 2, dest 0), then 0xBEEF0000, 0xBEEF0001, with ready_and_i = 01.
  - Required: all 3 flits appear only on output 0, one per cycle; v_o[1] stays 0.
- Broadcast packet:
  - Stimulus: header 0x0000002F, then 0xBEEF0002, 0xBEEF0003; ready_and_i[0] = 1, ready_and_i[1] toggling every cycle.
  - Required: each flit appears exactly once on both outputs; ready_and_o is asserted only after output 1 has accepted; no duplicates on output 0.
- Pass-through packet:
  - Stimulus: header 0x00000023, then 0xBEEF0004, 0xBEEF0005, with output 1 toggling ready.
  - Required: flits only on output 1, in order; ready_and_o mirrors ready_and_i[1].
- Zero-length packets:
  - Stimulus: headers 0x003, 0x00F, 0x000 back-to-back.
  - Required, in order:
    - 0x003 appears on output 1 only.
    - 0x00F appears on both outputs.
    - 0x000 appears on output 0 only.
  - Each packet is a single flit; the node returns to the header state after each.
- Reset:
  - Stimulus: hold reset_i = 0 with v_i = 1.
  - Required: v_o = 00 and ready_and_o = 0.
  - Stimulus: assert reset mid-broadcast.
  - Required: after release, the next flit is decoded as a header.
